pipeline_ctrl: RTL and testbench

Stall/flush controller for the five-stage pipeline. It drives per-stage enable and flush strobes into the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC. It detects load-use hazards, taken branches and jumps, and data-memory wait states. Those registers have no reset of their own, so this block also clears the whole pipeline after reset, and it keeps saturating stall and flush performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 77 +++++++
 rtl/pipeline_ctrl_sat_counter.sv | 38 +++
 rtl/pipeline_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller:
//   - FSM state encoding and writeback-select encodings
//   - pipeline depth used for the post-reset clear
//   - instruction field positions for rd/rs1/rs2
//   - control-vector type plus the hazard and RUN-decision helpers
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam int PIPE_DEPTH = 4;

  localparam int REG_W   = 5;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  // One bit per pipeline-register strobe, enables first then flushes.
  typedef struct packed {
    logic en_pc;
    logic en_if_id;
    logic en_id_ex;
    logic en_ex_mem;
    logic en_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic flush_mem_wb;
  } ctrl_t;

  localparam ctrl_t CTRL_INIT = 9'b00000_1111;  // bubble every register
  localparam ctrl_t CTRL_HOLD = 9'b00000_0000;  // freeze everything
  localparam ctrl_t CTRL_RUN  = 9'b11111_0000;  // free flow

  // Load in EX whose destination feeds either source of the ID instruction.
  // Both source fields are compared regardless of opcode (conservative).
  function automatic logic is_load_use(input logic [31:0] instr_id,
                                       input logic [31:0] instr_ex,
                                       input logic        regwen_ex,
                                       input logic [1:0]  wbsel_ex);
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    rd  = instr_ex[RD_LSB  +: REG_W];
    rs1 = instr_id[RS1_LSB +: REG_W];
    rs2 = instr_id[RS2_LSB +: REG_W];
    return regwen_ex && (wbsel_ex == WB_MEM) && (rd != 5'd0) &&
           ((rd == rs1) || (rd == rs2));
  endfunction

  // Control vector when no memory stall applies; a taken branch wins over
  // load-use because the dependent instruction is squashed anyway.
  function automatic ctrl_t run_decision(input logic pcsel, input logic load_use);
    ctrl_t c;
    c = CTRL_RUN;
    if (pcsel) begin
      c.flush_if_id = 1'b1;
      c.flush_id_ex = 1'b1;
    end else if (load_use) begin
      c.en_pc       = 1'b0;
      c.en_if_id    = 1'b0;
      c.flush_id_ex = 1'b1;
    end else begin
      c = CTRL_RUN;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk_i    in   clock, rising edge
//   clear_i  in   synchronous clear (wins over inc_i)
//   inc_i    in   count by one unless already all-ones
//   cnt_o    out  current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {W{1'b0}};
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Stall/flush controller for the five-stage pipeline. Clears the pipeline
// for PIPE_DEPTH cycles after reset, then resolves memory waits, taken
// branches and load-use hazards into per-register enable/flush strobes.
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   instr_ID, instr_EX                 instructions in decode / execute
//   RegWEn_EX, WBSel_EX, PCSel_EX      EX-stage control (load detect, branch)
//   mem_req_MEM, mem_ready_i           data-memory handshake
//   en_* / flush_*                     register strobes (combinational, Mealy)
//   mem_err_o                          sticky memory-timeout flag
//   stall_cnt_o, flush_cnt_o           saturating performance counters
//   state_o                            current FSM state
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      instr_ID,
  input  logic [31:0]      instr_EX,
  input  logic             RegWEn_EX,
  input  logic [1:0]       WBSel_EX,
  input  logic             PCSel_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ready_i,
  output logic             en_PC,
  output logic             en_IF_ID,
  output logic             en_ID_EX,
  output logic             en_EX_MEM,
  output logic             en_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             flush_MEM_WB,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       state_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [1:0]        INIT_LAST = 2'(PIPE_DEPTH - 1);

  state_e            state_q,    state_d;
  logic [1:0]        init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q,  mem_err_d;

  ctrl_t ctrl_fsm_s;
  ctrl_t ctrl_s;
  logic  load_use_s;
  logic  branch_s;
  logic  stall_inc_s;
  logic  flush_inc_s;

  // Instruction bits outside the register fields are not needed here.
  logic unused_s;
  assign unused_s = ^{instr_ID[31:25], instr_ID[14:0], instr_EX[31:12],
                      instr_EX[6:0], WB_ALU, WB_PC4};

  assign load_use_s = is_load_use(instr_ID, instr_EX, RegWEn_EX, WBSel_EX);

  // FSM next state, sequencing counters and raw control decision
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    ctrl_fsm_s = CTRL_INIT;
    branch_s   = 1'b0;
    case (state_q)
      INIT: begin
        ctrl_fsm_s = CTRL_INIT;
        if (init_cnt_q == INIT_LAST) begin
          state_d    = RUN;
          init_cnt_d = 2'd0;
        end else begin
          init_cnt_d = init_cnt_q + 2'd1;
        end
      end
      RUN: begin
        if (mem_req_MEM && !mem_ready_i) begin
          // The request cycle itself is the first stall cycle.
          ctrl_fsm_s = CTRL_HOLD;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          ctrl_fsm_s = run_decision(PCSel_EX, load_use_s);
          branch_s   = PCSel_EX;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready_i && (wait_cnt_q < WAIT_MAX)) begin
          ctrl_fsm_s = CTRL_HOLD;
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end else begin
          // Ready or timed out: apply whatever hazard was held during the wait.
          ctrl_fsm_s = run_decision(PCSel_EX, load_use_s);
          branch_s   = PCSel_EX;
          state_d    = RUN;
          mem_err_d  = mem_err_q | ~mem_ready_i;
        end
      end
      default: begin
        ctrl_fsm_s = CTRL_INIT;
        state_d    = INIT;
        init_cnt_d = 2'd0;
      end
    endcase
  end

  // Reset low forces the clearing pattern regardless of the stored state.
  assign ctrl_s      = rst_ni ? ctrl_fsm_s : CTRL_INIT;
  assign stall_inc_s = rst_ni && (state_q != INIT) && !ctrl_s.en_pc;
  assign flush_inc_s = rst_ni && branch_s;

  // FSM state, init/wait counters and sticky timeout flag
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      init_cnt_q <= 2'd0;
      wait_cnt_q <= {WAIT_W{1'b0}};
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .clear_i (~rst_ni),
    .inc_i   (stall_inc_s),
    .cnt_o   (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .clear_i (~rst_ni),
    .inc_i   (flush_inc_s),
    .cnt_o   (flush_cnt_o)
  );

  assign en_PC        = ctrl_s.en_pc;
  assign en_IF_ID     = ctrl_s.en_if_id;
  assign en_ID_EX     = ctrl_s.en_id_ex;
  assign en_EX_MEM    = ctrl_s.en_ex_mem;
  assign en_MEM_WB    = ctrl_s.en_mem_wb;
  assign flush_IF_ID  = ctrl_s.flush_if_id;
  assign flush_ID_EX  = ctrl_s.flush_id_ex;
  assign flush_EX_MEM = ctrl_s.flush_ex_mem;
  assign flush_MEM_WB = ctrl_s.flush_mem_wb;
  assign mem_err_o    = mem_err_q;
  assign state_o      = rst_ni ? state_q : INIT;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Directed scenarios with literal expectations, followed by randomized
// traffic, all checked every cycle against a behavioural model of the
// stall/flush rules (counts of boot cycles, outstanding wait length, totals).
module tb_pipeline_ctrl;

  localparam int TMO = 8;
  localparam int CW  = 32;
  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [31:0]   instr_ID, instr_EX;
  logic          RegWEn_EX, PCSel_EX, mem_req_MEM, mem_ready_i;
  logic [1:0]    WBSel_EX;
  logic          en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB;
  logic          flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
  logic          mem_err_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;
  logic [1:0]    state_o;

  always #5 clk_i = ~clk_i;

  pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_ID(instr_ID), .instr_EX(instr_EX),
    .RegWEn_EX(RegWEn_EX), .WBSel_EX(WBSel_EX), .PCSel_EX(PCSel_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ready_i(mem_ready_i),
    .en_PC(en_PC), .en_IF_ID(en_IF_ID), .en_ID_EX(en_ID_EX),
    .en_EX_MEM(en_EX_MEM), .en_MEM_WB(en_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .flush_EX_MEM(flush_EX_MEM), .flush_MEM_WB(flush_MEM_WB),
    .mem_err_o(mem_err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
    .state_o(state_o)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     boot_left = 4;   // clearing cycles still owed after reset
  bit     waiting   = 1'b0;
  int     waited    = 0;   // stall cycles spent on the current access
  longint m_stall   = 0;
  longint m_flush   = 0;
  bit     m_err     = 1'b0;

  function automatic bit lu(input logic [31:0] id, input logic [31:0] ex,
                            input logic we, input logic [1:0] wb);
    int rd, rs1, rs2;
    rd  = int'((ex >> 7)  & 32'd31);
    rs1 = int'((id >> 15) & 32'd31);
    rs2 = int'((id >> 20) & 32'd31);
    return we && (wb == 2'd0) && (rd != 0) && (rd == rs1 || rd == rs2);
  endfunction

  always @(negedge clk_i) begin
    logic [8:0] exp_c;
    logic [1:0] exp_st;
    bit blk, br;
    if (chk_on) begin
      blk = 1'b0;
      br  = 1'b0;
      if (!rst_ni || boot_left > 0) begin
        exp_c  = 9'b00000_1111;
        exp_st = 2'd0;
      end else begin
        if (waiting) blk = !mem_ready_i && (waited < TMO);
        else         blk = mem_req_MEM && !mem_ready_i;
        if (blk)                                      exp_c = 9'b00000_0000;
        else if (PCSel_EX) begin                      exp_c = 9'b11111_1100; br = 1'b1; end
        else if (lu(instr_ID, instr_EX, RegWEn_EX, WBSel_EX)) exp_c = 9'b00111_0100;
        else                                          exp_c = 9'b11111_0000;
        exp_st = waiting ? 2'd2 : 2'd1;
      end
      check("ctrl", {en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB,
                     flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB}, exp_c);
      check("state", state_o, exp_st);
      check("mem_err", mem_err_o, m_err);
      check("stall_cnt", stall_cnt_o, m_stall);
      check("flush_cnt", flush_cnt_o, m_flush);
      // advance the model to the next cycle
      if (!rst_ni) begin
        boot_left = 4; waiting = 1'b0; waited = 0;
        m_stall = 0; m_flush = 0; m_err = 1'b0;
      end else if (boot_left > 0) begin
        boot_left--;
      end else begin
        if (!exp_c[8] && m_stall < CMAX) m_stall++;
        if (br && m_flush < CMAX) m_flush++;
        if (blk) begin
          waited  = waiting ? waited + 1 : 1;
          waiting = 1'b1;
        end else begin
          if (waiting && !mem_ready_i) m_err = 1'b1;
          waiting = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    instr_ID = 32'h0000_0013; instr_EX = 32'h0000_0013;
    RegWEn_EX = 1'b0; WBSel_EX = 2'd1; PCSel_EX = 1'b0;
    mem_req_MEM = 1'b0; mem_ready_i = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic samp();
    @(negedge clk_i);
  endtask

  task automatic set_lw_use();
    instr_EX = 32'h0000_A283; RegWEn_EX = 1'b1; WBSel_EX = 2'd0;
    instr_ID = 32'h0072_8333;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  initial begin
    int n, first_en;
    bit slow;
    rst_ni = 1'b0;
    idle();
    @(posedge clk_i); #1 chk_on = 1'b1;
    nxt();
    rst_ni = 1'b1;

    // Reset release: 4 clearing cycles, en_PC first in cycle 5
    n = 0; first_en = 0;
    for (int c = 1; c <= 5; c++) begin
      samp();
      if (flush_IF_ID && flush_ID_EX && flush_EX_MEM && flush_MEM_WB) n++;
      if (en_PC && first_en == 0) first_en = c;
      nxt();
    end
    check("init_flush_cycles", n, 4);
    check("first_en_pc_cycle", first_en, 5);
    check("reset_stall_cnt", stall_cnt_o, 0);
    check("reset_flush_cnt", flush_cnt_o, 0);

    // Load-use: one bubble
    set_lw_use();
    samp();
    check("lu_en_pc_if_id", {en_PC, en_IF_ID}, 2'b00);
    check("lu_flush_id_ex", flush_ID_EX, 1);
    nxt(); idle(); samp();
    check("lu_stall_cnt", stall_cnt_o, 1);
    // rd = x0 never stalls, even against rs1 = x0
    nxt();
    instr_EX = 32'h0000_A003; RegWEn_EX = 1'b1; WBSel_EX = 2'd0; instr_ID = 32'h0070_0333;
    samp();
    check("x0_no_stall", en_PC, 1);

    // Taken branch
    nxt(); idle(); PCSel_EX = 1'b1;
    samp();
    check("br_strobes", {flush_IF_ID, flush_ID_EX, flush_EX_MEM, en_PC, en_MEM_WB}, 5'b11011);
    nxt(); idle(); samp();
    check("br_flush_cnt", flush_cnt_o, 1);
    // Branch together with load-use: branch behaviour only
    nxt(); set_lw_use(); PCSel_EX = 1'b1;
    samp();
    check("br_lu_strobes", {en_PC, en_IF_ID, flush_IF_ID, flush_ID_EX}, 4'b1111);
    nxt(); idle(); samp();
    check("br_lu_flush_cnt", flush_cnt_o, 2);
    check("br_lu_stall_cnt", stall_cnt_o, 1);

    // Memory wait: ready after 3 cycles
    nxt(); mem_req_MEM = 1'b1; mem_ready_i = 1'b0;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      samp();
      if (!en_PC && !en_MEM_WB) n++;
      nxt();
    end
    mem_ready_i = 1'b1;
    samp();
    check("mw_stall_cycles", n, 3);
    check("mw_ready_en", {en_PC, en_IF_ID, en_MEM_WB}, 3'b111);
    nxt(); idle(); samp();
    check("mw_stall_cnt", stall_cnt_o, 4);

    // Timeout: ready never comes
    nxt(); mem_req_MEM = 1'b1; mem_ready_i = 1'b0;
    n = 0;
    for (int c = 1; c <= 8; c++) begin
      samp();
      if (!en_PC) n++;
      nxt();
    end
    samp();
    check("to_stall_cycles", n, 8);
    check("to_release_cycle9", en_PC, 1);
    check("to_err_not_yet", mem_err_o, 0);
    nxt(); idle(); samp();
    check("to_err_set", mem_err_o, 1);
    check("to_state_run", state_o, 1);
    check("to_stall_cnt", stall_cnt_o, 12);
    nxt(); samp();
    check("to_err_held", mem_err_o, 1);

    // Branch held across a 2-cycle wait: flushed once, on exit
    nxt(); PCSel_EX = 1'b1; mem_req_MEM = 1'b1; mem_ready_i = 1'b0;
    samp(); check("sim_wait1_noflush", {flush_IF_ID, en_PC}, 2'b00);
    nxt(); samp(); check("sim_wait2_noflush", {flush_IF_ID, en_PC}, 2'b00);
    nxt(); mem_ready_i = 1'b1;
    samp(); check("sim_exit_flush", {flush_IF_ID, flush_ID_EX, en_PC}, 3'b111);
    nxt(); idle(); samp();
    check("sim_flush_cnt", flush_cnt_o, 3);
    check("sim_stall_cnt", stall_cnt_o, 14);

    // Reset in the middle of a wait
    nxt(); mem_req_MEM = 1'b1; mem_ready_i = 1'b0;
    nxt(); samp();
    check("rst_mid_state_wait", state_o, 2);
    nxt(); rst_ni = 1'b0;
    samp();
    check("rst_mid_forced", {en_PC, flush_IF_ID, flush_MEM_WB}, 3'b011);
    nxt(); samp();
    check("rst_mid_state", state_o, 0);
    check("rst_mid_err", mem_err_o, 0);
    check("rst_mid_cnts", {stall_cnt_o, flush_cnt_o}, 64'd0);
    nxt(); rst_ni = 1'b1; idle();

    // Randomized traffic against the model
    slow = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      nxt();
      if ($urandom_range(0, 49) == 0) slow = ~slow;
      rst_ni      = ($urandom_range(0, 399) != 0);
      instr_ID    = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      instr_EX    = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      RegWEn_EX   = 1'($urandom_range(0, 1));
      WBSel_EX    = 2'($urandom_range(0, 2));
      PCSel_EX    = ($urandom_range(0, 7) == 0);
      mem_req_MEM = ($urandom_range(0, 3) == 0);
      mem_ready_i = slow ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
    end
    nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
